fb_write_arbiter: RTL

//  Shares the single VGA frame-buffer write port (addr/data/write-a-pixel) among
//  NUM_REQ pixel producers (board drawer, cursor/highlight overlay, status/text).

---
 rtl/fb_write_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fb_write_arbiter.sv
// Purpose: round-robin arbiter sharing one frame-buffer write port among NUM_REQ pixel producers, with burst ownership and a burst-length cap.
// Latency: req->gnt 1 cycle from IDLE; owner wr_en->fb_we 1 cycle (registered addr/data/we); at least one idle cycle between owners.
// Backpressure: requesters watch gnt; the owner loses the port on last, on dropping req, or when MAX_BURST is hit while another requester waits.
//   Optional build macro FB_ARB_VBLANK_GATE_EN: new grants are only issued while vblank_i is high.
module fb_write_arbiter #(
   parameter int NUM_REQ   = 3,
   parameter int ADDR_W    = 15,
   parameter int DATA_W    = 24,
   parameter int MAX_BURST = 256
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ-1:0]        last_i,
   input  logic [NUM_REQ-1:0]        wr_en_i,
   input  logic [NUM_REQ*ADDR_W-1:0] wr_addr_i,
   input  logic [NUM_REQ*DATA_W-1:0] wr_data_i,
   input  logic                      vblank_i,
   output logic [NUM_REQ-1:0]        gnt_o,
   output logic [ADDR_W-1:0]         fb_addr_o,
   output logic [DATA_W-1:0]         fb_data_o,
   output logic                      fb_we_o,
   output logic                      busy_o
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_OWN  = 1'b1;

   // Beat count at which the current write is the last one allowed before yielding.
   localparam logic [BW-1:0] CAP = BW'(MAX_BURST - 1);

   logic [0:0]         state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [BW-1:0]      beat_cnt_q, beat_cnt_d;
   logic               fb_we_q, fb_we_d;
   logic [ADDR_W-1:0]  fb_addr_q, fb_addr_d;
   logic [DATA_W-1:0]  fb_data_q, fb_data_d;

   logic               win_vld;
   logic [PW-1:0]      win_idx;
   int                 cand;
   logic               grant_ok;

   logic               own_wr;
   logic               own_last;
   logic               own_req;
   logic [ADDR_W-1:0]  own_addr;
   logic [DATA_W-1:0]  own_data;
   logic               other_pend;
   logic               burst_end;

`ifdef FB_ARB_VBLANK_GATE_EN
   // New owners only start during vertical blank; running bursts are not cut.
   assign grant_ok = vblank_i;
`else
   logic unused_vblank;
   assign unused_vblank = vblank_i;
   assign grant_ok      = 1'b1;
`endif

   // Round-robin pick: first asserted request after the last winner, wrapping.
   always_comb begin
      win_vld = 1'b0;
      win_idx = rr_ptr_q;
      cand    = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = int'(rr_ptr_q) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!win_vld && req_i[cand]) begin
            win_vld = 1'b1;
            win_idx = PW'(cand);
         end
      end
   end

   // Select the current owner's strobes and payload using the one-hot grant.
   always_comb begin
      own_wr   = 1'b0;
      own_last = 1'b0;
      own_req  = 1'b0;
      own_addr = '0;
      own_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_q[i]) begin
            own_wr   = wr_en_i[i];
            own_last = last_i[i];
            own_req  = req_i[i];
            own_addr = wr_addr_i[i*ADDR_W +: ADDR_W];
            own_data = wr_data_i[i*DATA_W +: DATA_W];
         end
      end
   end

   assign other_pend = |(req_i & ~gnt_q);

   // The owner yields on its last write, on dropping req, or on the capped beat while someone waits.
   assign burst_end = (own_wr && own_last) || !own_req ||
                      (own_wr && (beat_cnt_q == CAP) && other_pend);

   // Next-state: grant selection in IDLE, write forwarding and burst accounting in OWN.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      fb_we_d    = 1'b0;
      fb_addr_d  = fb_addr_q;
      fb_data_d  = fb_data_q;
      case (state_q)
         S_IDLE: begin
            if (win_vld && grant_ok) begin
               state_d    = S_OWN;
               gnt_d      = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
               rr_ptr_d   = win_idx;
               beat_cnt_d = '0;
            end
         end
         S_OWN: begin
            if (own_wr) begin
               fb_we_d    = 1'b1;
               fb_addr_d  = own_addr;
               fb_data_d  = own_data;
               beat_cnt_d = (beat_cnt_q == CAP) ? '0 : beat_cnt_q + 1'b1;
            end
            if (burst_end) begin
               state_d = S_IDLE;
               gnt_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // State registers; reset drops any in-flight write and makes requester 0 win first.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         gnt_q      <= '0;
         rr_ptr_q   <= PW'(NUM_REQ - 1);
         beat_cnt_q <= '0;
         fb_we_q    <= 1'b0;
         fb_addr_q  <= '0;
         fb_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         fb_we_q    <= fb_we_d;
         fb_addr_q  <= fb_addr_d;
         fb_data_q  <= fb_data_d;
      end
   end

   assign gnt_o     = gnt_q;
   assign fb_we_o   = fb_we_q;
   assign fb_addr_o = fb_addr_q;
   assign fb_data_o = fb_data_q;
   assign busy_o    = (state_q == S_OWN);

endmodule
